// File: rtl/mdu_pkg.sv
// Shared constants for the multiply/divide unit: op encodings, FSM states, default width.
package mdu_pkg;

   localparam int unsigned MDU_WIDTH = 32;

   typedef logic [2:0] mdu_op_t;

   localparam mdu_op_t MDU_MULT  = 3'b000;
   localparam mdu_op_t MDU_MULTU = 3'b001;
   localparam mdu_op_t MDU_DIV   = 3'b010;
   localparam mdu_op_t MDU_DIVU  = 3'b011;
   localparam mdu_op_t MDU_MTHI  = 3'b100;
   localparam mdu_op_t MDU_MTLO  = 3'b101;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the remainder, try to subtract.
module mdu_div_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH:0]   i_rem,
   input  logic [WIDTH-1:0] i_quo,
   input  logic [WIDTH-1:0] i_dvs,
   output logic [WIDTH:0]   o_rem,
   output logic [WIDTH-1:0] o_quo
);

   localparam int unsigned SW = WIDTH + 2;

   logic [SW-1:0] w_shift;
   logic [SW-1:0] w_diff;
   logic          w_take;

   // Remainder stays below the divisor, so the top bit of w_diff is a clean borrow flag.
   assign w_shift = {i_rem, i_quo[WIDTH-1]};
   assign w_diff  = w_shift - {2'b00, i_dvs};
   assign w_take  = ~w_diff[SW-1];

   assign o_rem = w_take ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
   assign o_quo = {i_quo[WIDTH-2:0], w_take};

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO and start/busy/done handshake.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int unsigned WIDTH = MDU_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned W2    = 2 * WIDTH;
   localparam int unsigned CNT_W = $clog2(WIDTH);

   logic [1:0]       r_state;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [CNT_W-1:0] r_cnt;
   logic             r_is_div;
   logic             r_neg_res;
   logic             r_neg_rem;
   logic             r_dvz;
   logic [WIDTH-1:0] r_opa_abs;
   logic [WIDTH-1:0] r_opb_abs;
   logic [W2-1:0]    r_prod;
   logic [WIDTH:0]   r_rem;
   logic [WIDTH-1:0] r_quo;

   logic [1:0]       w_state_nxt;
   logic             w_busy_nxt;
   logic             w_done_nxt;
   logic [WIDTH-1:0] w_hi_nxt;
   logic [WIDTH-1:0] w_lo_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_is_div_nxt;
   logic             w_neg_res_nxt;
   logic             w_neg_rem_nxt;
   logic             w_dvz_nxt;
   logic [WIDTH-1:0] w_opa_abs_nxt;
   logic [WIDTH-1:0] w_opb_abs_nxt;
   logic [W2-1:0]    w_prod_nxt;
   logic [WIDTH:0]   w_rem_nxt;
   logic [WIDTH-1:0] w_quo_nxt;

   logic             w_is_md_op;
   logic             w_signed_op;
   logic             w_sa;
   logic             w_sb;
   logic [WIDTH-1:0] w_opa_abs;
   logic [WIDTH-1:0] w_opb_abs;
   logic [WIDTH:0]   w_mul_sum;
   logic [W2-1:0]    w_mul_step;
   logic [WIDTH:0]   w_div_rem;
   logic [WIDTH-1:0] w_div_quo;
   logic [W2-1:0]    w_prod_fix;
   logic [WIDTH-1:0] w_quo_fix;
   logic [WIDTH-1:0] w_rem_fix;

   // Operand preparation at issue: magnitudes and sign flags.
   assign w_is_md_op  = (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
   assign w_signed_op = (op == MDU_MULT) || (op == MDU_DIV);
   assign w_sa        = w_signed_op & opa[WIDTH-1];
   assign w_sb        = w_signed_op & opb[WIDTH-1];
   assign w_opa_abs   = w_sa ? (~opa + WIDTH'(1)) : opa;
   assign w_opb_abs   = w_sb ? (~opb + WIDTH'(1)) : opb;

   // Shift-add multiply step: conditional add into the upper half, then shift right.
   assign w_mul_sum  = {1'b0, r_prod[W2-1:WIDTH]} + (r_prod[0] ? {1'b0, r_opa_abs} : (WIDTH+1)'(0));
   assign w_mul_step = {w_mul_sum, r_prod[WIDTH-1:1]};

   mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
      .i_rem (r_rem),
      .i_quo (r_quo),
      .i_dvs (r_opb_abs),
      .o_rem (w_div_rem),
      .o_quo (w_div_quo)
   );

   // Sign fix-up; a zero divisor forces an all-ones quotient while the remainder is the dividend.
   assign w_prod_fix = r_neg_res ? (~r_prod + W2'(1)) : r_prod;
   assign w_quo_fix  = r_dvz ? {WIDTH{1'b1}} : (r_neg_res ? (~r_quo + WIDTH'(1)) : r_quo);
   assign w_rem_fix  = r_neg_rem ? (~r_rem[WIDTH-1:0] + WIDTH'(1)) : r_rem[WIDTH-1:0];

   always_comb begin
      w_state_nxt   = r_state;
      w_busy_nxt    = r_busy;
      w_done_nxt    = 1'b0;
      w_hi_nxt      = r_hi;
      w_lo_nxt      = r_lo;
      w_cnt_nxt     = r_cnt;
      w_is_div_nxt  = r_is_div;
      w_neg_res_nxt = r_neg_res;
      w_neg_rem_nxt = r_neg_rem;
      w_dvz_nxt     = r_dvz;
      w_opa_abs_nxt = r_opa_abs;
      w_opb_abs_nxt = r_opb_abs;
      w_prod_nxt    = r_prod;
      w_rem_nxt     = r_rem;
      w_quo_nxt     = r_quo;

      if (flush) begin
         w_state_nxt = ST_IDLE;
         w_busy_nxt  = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start && w_is_md_op) begin
                  w_state_nxt   = ST_CALC;
                  w_busy_nxt    = 1'b1;
                  w_cnt_nxt     = '0;
                  w_is_div_nxt  = op[1];
                  w_neg_res_nxt = w_sa ^ w_sb;
                  w_neg_rem_nxt = w_sa;
                  w_dvz_nxt     = (opb == '0);
                  w_opa_abs_nxt = w_opa_abs;
                  w_opb_abs_nxt = w_opb_abs;
                  w_prod_nxt    = {{WIDTH{1'b0}}, w_opb_abs};
                  w_rem_nxt     = '0;
                  w_quo_nxt     = w_opa_abs;
               end else if (start && (op == MDU_MTHI)) begin
                  w_hi_nxt = opa;
               end else if (start && (op == MDU_MTLO)) begin
                  w_lo_nxt = opa;
               end
            end
            ST_CALC: begin
               if (r_is_div) begin
                  w_rem_nxt = w_div_rem;
                  w_quo_nxt = w_div_quo;
               end else begin
                  w_prod_nxt = w_mul_step;
               end
               w_cnt_nxt = r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(WIDTH - 1)) begin
                  w_state_nxt = ST_FIX;
               end
            end
            ST_FIX: begin
               if (r_is_div) begin
                  w_hi_nxt = w_rem_fix;
                  w_lo_nxt = w_quo_fix;
               end else begin
                  w_hi_nxt = w_prod_fix[W2-1:WIDTH];
                  w_lo_nxt = w_prod_fix[WIDTH-1:0];
               end
               w_state_nxt = ST_IDLE;
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_busy_nxt  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_cnt     <= '0;
         r_is_div  <= 1'b0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_dvz     <= 1'b0;
         r_opa_abs <= '0;
         r_opb_abs <= '0;
         r_prod    <= '0;
         r_rem     <= '0;
         r_quo     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_hi      <= w_hi_nxt;
         r_lo      <= w_lo_nxt;
         r_cnt     <= w_cnt_nxt;
         r_is_div  <= w_is_div_nxt;
         r_neg_res <= w_neg_res_nxt;
         r_neg_rem <= w_neg_rem_nxt;
         r_dvz     <= w_dvz_nxt;
         r_opa_abs <= w_opa_abs_nxt;
         r_opb_abs <= w_opb_abs_nxt;
         r_prod    <= w_prod_nxt;
         r_rem     <= w_rem_nxt;
         r_quo     <= w_quo_nxt;
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: arithmetic results, handshake timing, flush and reset.
module tb_mult_div_unit;
   import mdu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] opa;
   logic [31:0] opb;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_cmp = 0;
   int n_err = 0;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .opa   (opa),
      .opb   (opb),
      .flush (flush),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one op, then observe n negedge samples (sample k follows the k-th edge after issue).
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int n, output int nb, output int nd, output int dat);
      @(negedge clk);
      start = 1'b1; op = o; opa = a; opb = b;
      @(negedge clk);
      start = 1'b0; opa = $urandom; opb = $urandom;
      nb = 0; nd = 0; dat = -1;
      for (int k = 0; k < n; k++) begin
         if (k > 0) @(negedge clk);
         if (busy) nb++;
         if (done) begin
            nd++;
            if (dat < 0) dat = k;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; op = 3'b000; opa = '0; opb = '0; flush = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
      n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL reset_hi got=%h exp=0", hi); end
      n_cmp++; if (lo !== 32'h0) begin n_err++; $display("FAIL reset_lo got=%h exp=0", lo); end
      rst_n = 1'b1;
   endtask

   task automatic test_multu;
      int nb, nd, dat;
      run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 40, nb, nd, dat);
      n_cmp++; if (hi !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_hi got=%h exp=fffffffe", hi); end
      n_cmp++; if (lo !== 32'h0000_0001) begin n_err++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
      n_cmp++; if (nb != 33) begin n_err++; $display("FAIL multu_busy_cycles got=%0d exp=33", nb); end
      n_cmp++; if (nd != 1) begin n_err++; $display("FAIL multu_done_pulses got=%0d exp=1", nd); end
      n_cmp++; if (dat != 33) begin n_err++; $display("FAIL multu_done_edge got=%0d exp=33", dat); end
   endtask

   task automatic test_mult;
      int nb, nd, dat;
      run_op(MDU_MULT, 32'hFFFF_FFFD, 32'd5, 36, nb, nd, dat);
      n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
      n_cmp++; if (lo !== 32'hFFFF_FFF1) begin n_err++; $display("FAIL mult_lo got=%h exp=fffffff1", lo); end
      n_cmp++; if (nd != 1) begin n_err++; $display("FAIL mult_done_pulses got=%0d exp=1", nd); end
   endtask

   task automatic test_div;
      int nb, nd, dat;
      run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 36, nb, nd, dat);
      n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
      n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
      n_cmp++; if (dat != 33) begin n_err++; $display("FAIL div_done_edge got=%0d exp=33", dat); end
   endtask

   task automatic test_div_overflow;
      int nb, nd, dat;
      run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 36, nb, nd, dat);
      n_cmp++; if (lo !== 32'h8000_0000) begin n_err++; $display("FAIL divovf_lo got=%h exp=80000000", lo); end
      n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL divovf_hi got=%h exp=00000000", hi); end
   endtask

   task automatic test_div_by_zero;
      int nb, nd, dat;
      run_op(MDU_DIVU, 32'd100, 32'd0, 36, nb, nd, dat);
      n_cmp++; if (lo !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divu0_lo got=%h exp=ffffffff", lo); end
      n_cmp++; if (hi !== 32'd100) begin n_err++; $display("FAIL divu0_hi got=%h exp=00000064", hi); end
      n_cmp++; if (dat != 33) begin n_err++; $display("FAIL divu0_done_edge got=%0d exp=33", dat); end
      run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd0, 36, nb, nd, dat);
      n_cmp++; if (lo !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div0_lo got=%h exp=ffffffff", lo); end
      n_cmp++; if (hi !== 32'hFFFF_FFF9) begin n_err++; $display("FAIL div0_hi got=%h exp=fffffff9", hi); end
   endtask

   task automatic test_mthi_mtlo;
      int nb;
      nb = 0;
      @(negedge clk);
      start = 1'b1; op = MDU_MTHI; opa = 32'h0000_1234;
      @(negedge clk);
      if (busy) nb++;
      op = MDU_MTLO; opa = 32'h0000_5678;
      @(negedge clk);
      if (busy) nb++;
      start = 1'b0;
      @(negedge clk);
      if (busy) nb++;
      n_cmp++; if (hi !== 32'h0000_1234) begin n_err++; $display("FAIL mthi_hi got=%h exp=00001234", hi); end
      n_cmp++; if (lo !== 32'h0000_5678) begin n_err++; $display("FAIL mtlo_lo got=%h exp=00005678", lo); end
      n_cmp++; if (nb != 0) begin n_err++; $display("FAIL mtx_busy_samples got=%0d exp=0", nb); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL mtx_done got=%b exp=0", done); end
   endtask

   task automatic test_flush_start;
      @(negedge clk);
      start = 1'b1; op = MDU_MTHI; opa = 32'h0000_2222; flush = 1'b1;
      @(negedge clk);
      start = 1'b1; op = MDU_MULTU; opa = 32'd3; opb = 32'd4; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      n_cmp++; if (hi !== 32'h0000_1234) begin n_err++; $display("FAIL flushstart_hi got=%h exp=00001234", hi); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flushstart_busy got=%b exp=0", busy); end
   endtask

   task automatic test_flush;
      int nd;
      nd = 0;
      @(negedge clk);
      start = 1'b1; op = MDU_DIVU; opa = 32'd100; opb = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy got=%b exp=0", busy); end
      for (int k = 0; k < 40; k++) begin
         if (done) nd++;
         @(negedge clk);
      end
      n_cmp++; if (nd != 0) begin n_err++; $display("FAIL flush_done_pulses got=%0d exp=0", nd); end
      n_cmp++; if (hi !== 32'h0000_1234) begin n_err++; $display("FAIL flush_hi got=%h exp=00001234", hi); end
      n_cmp++; if (lo !== 32'h0000_5678) begin n_err++; $display("FAIL flush_lo got=%h exp=00005678", lo); end
   endtask

   task automatic test_start_while_busy;
      int nb, nd, dat;
      @(negedge clk);
      start = 1'b1; op = MDU_DIVU; opa = 32'd100; opb = 32'd7;
      @(negedge clk);
      start = 1'b0; opa = 32'hDEAD_BEEF; opb = 32'h0;
      repeat (4) @(negedge clk);
      start = 1'b1; op = MDU_MULTU; opa = 32'd3; opb = 32'd4;
      @(negedge clk);
      start = 1'b1; op = MDU_MTHI; opa = 32'hBAD0_0000;
      @(negedge clk);
      start = 1'b0;
      nb = 0; nd = 0; dat = -1;
      for (int k = 6; k < 40; k++) begin
         if (busy) nb++;
         if (done) begin
            nd++;
            if (dat < 0) dat = k;
         end
         @(negedge clk);
      end
      n_cmp++; if (lo !== 32'd14) begin n_err++; $display("FAIL swb_lo got=%h exp=0000000e", lo); end
      n_cmp++; if (hi !== 32'd2) begin n_err++; $display("FAIL swb_hi got=%h exp=00000002", hi); end
      n_cmp++; if (nd != 1) begin n_err++; $display("FAIL swb_done_pulses got=%0d exp=1", nd); end
      n_cmp++; if (dat != 33) begin n_err++; $display("FAIL swb_done_edge got=%0d exp=33", dat); end
   endtask

   task automatic test_reset_mid;
      int nd;
      nd = 0;
      @(negedge clk);
      start = 1'b1; op = MDU_DIVU; opa = 32'd100; opb = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL rstmid_hi got=%h exp=0", hi); end
      n_cmp++; if (lo !== 32'h0) begin n_err++; $display("FAIL rstmid_lo got=%h exp=0", lo); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done || busy) nd++;
      end
      n_cmp++; if (nd != 0) begin n_err++; $display("FAIL rstmid_activity got=%0d exp=0", nd); end
   endtask

   initial begin
      test_reset();
      test_multu();
      test_mult();
      test_div();
      test_div_overflow();
      test_div_by_zero();
      test_mthi_mtlo();
      test_flush_start();
      test_flush();
      test_start_while_busy();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
